// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared register-file defaults and the address/data types used by
//            decode and writeback.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_xlen  = 32;
    localparam int c_depth = 32;
    localparam int c_nrd   = 2;
    localparam int c_aw    = $clog2(c_depth);

    typedef logic [c_aw-1:0]   reg_addr_t;
    typedef logic [c_xlen-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Per-register pending-write busy bits with set-over-clear priority
//            and an NRD-port lookup of the post-edge busy state.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH = c_depth,
    parameter  int NRD   = c_nrd,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                stall,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_add,
    input  logic                wen,
    input  logic [AW-1:0]       wadd,
    input  logic [NRD*AW-1:0]   radd,
    output logic [NRD-1:0]      busy_nxt
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    // Clear is applied before set so a same-cycle reissue keeps the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (!stall) begin
            if (wen)
                w_busy_nxt[wadd] = 1'b0;
            if (sb_set)
                w_busy_nxt[sb_add] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            r_busy <= '0;
        else if (!stall)
            r_busy <= w_busy_nxt;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_lookup
        assign busy_nxt[p] = w_busy_nxt[radd[p*AW +: AW]];
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-read-port register file with registered reads, hardwired
//            x0, stall hold and pending-write scoreboard.
//            Optional same-edge write-to-read bypass: REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = c_xlen,
    parameter  int DEPTH = c_depth,
    parameter  int NRD   = c_nrd,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                stall,
    input  logic                ren,
    input  logic [NRD*AW-1:0]   radd,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                wen,
    input  logic [AW-1:0]       wadd,
    input  logic [XLEN-1:0]     wdata,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_add
);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [NRD-1:0]  w_busy_nxt;
    logic            w_wr_live;

    assign w_wr_live = wen && (wadd != '0);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (!stall && w_wr_live) begin
            r_mem[wadd] <= wdata;
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD)
    ) u_scoreboard (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .stall    (stall),
        .sb_set   (sb_set),
        .sb_add   (sb_add),
        .wen      (wen),
        .wadd     (wadd),
        .radd     (radd),
        .busy_nxt (w_busy_nxt)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rval;
        logic [XLEN-1:0] r_data;
        logic            r_busy;

        assign w_ra = radd[p*AW +: AW];

`ifdef REGFILE_BYPASS_EN
        assign w_rval = (w_ra == '0)                   ? '0    :
                        (w_wr_live && (wadd == w_ra)) ? wdata :
                                                         r_mem[w_ra];
`else
        assign w_rval = (w_ra == '0) ? '0 : r_mem[w_ra];
`endif

        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                r_data <= '0;
                r_busy <= 1'b0;
            end else if (!stall) begin
                r_data <= ren ? w_rval : '0;
                r_busy <= ren ? w_busy_nxt[p] : 1'b0;
            end
        end

        assign rdata[p*XLEN +: XLEN] = r_data;
        assign rbusy[p]              = r_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp (NRD = 4) against an
//            array-based reference model, directed plus randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 4;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                CLK = 1'b0;
    logic                RSTn = 1'b0;
    logic                stall = 1'b0;
    logic                ren = 1'b0;
    logic [NRD*AW-1:0]   radd = '0;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                wen = 1'b0;
    logic [AW-1:0]       wadd = '0;
    logic [XLEN-1:0]     wdata = '0;
    logic                sb_set = 1'b0;
    logic [AW-1:0]       sb_add = '0;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] mdl_reg  [DEPTH];
    logic            mdl_busy [DEPTH];
    logic [XLEN-1:0] exp_rd   [NRD];
    logic            exp_rb   [NRD];

    always #5 CLK = ~CLK;

    regfile_mp #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .NRD   (NRD)
    ) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .stall  (stall),
        .ren    (ren),
        .radd   (radd),
        .rdata  (rdata),
        .rbusy  (rbusy),
        .wen    (wen),
        .wadd   (wadd),
        .wdata  (wdata),
        .sb_set (sb_set),
        .sb_add (sb_add)
    );

    function automatic logic [XLEN-1:0] rd(int p);
        return rdata[p*XLEN +: XLEN];
    endfunction

    task automatic set_radd(int p, int a);
        radd[p*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        stall = 1'b0; ren = 1'b0; wen = 1'b0; sb_set = 1'b0;
        radd = '0; wadd = '0; wdata = '0; sb_add = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mdl_reg[i]  = '0;
            mdl_busy[i] = 1'b0;
        end
        for (int p = 0; p < NRD; p++) begin
            exp_rd[p] = '0;
            exp_rb[p] = 1'b0;
        end
    endtask

    // Advance one clock: model the edge from the architectural rules, then sample at edge+1.
    task automatic step();
        logic nb [DEPTH];
        int   a;
        if (!stall) begin
            for (int i = 0; i < DEPTH; i++) nb[i] = mdl_busy[i];
            if (wen && wadd != 0) nb[wadd] = 1'b0;
            if (sb_set && sb_add != 0) nb[sb_add] = 1'b1;
            for (int p = 0; p < NRD; p++) begin
                a = int'(radd[p*AW +: AW]);
                if (!ren) begin
                    exp_rd[p] = '0;
                    exp_rb[p] = 1'b0;
                end else begin
                    if (a == 0)
                        exp_rd[p] = '0;
                    else if (BYP && wen && int'(wadd) == a)
                        exp_rd[p] = wdata;
                    else
                        exp_rd[p] = mdl_reg[a];
                    exp_rb[p] = nb[a];
                end
            end
            if (wen && wadd != 0) mdl_reg[wadd] = wdata;
            for (int i = 0; i < DEPTH; i++) mdl_busy[i] = nb[i];
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd(p) !== '0 || rbusy[p] !== 1'b0) begin
                failures++;
                $display("FAIL reset_init port%0d: rdata=%h busy=%b required 0/0", p, rd(p), rbusy[p]);
            end
        end
        @(posedge CLK); #1;
        RSTn = 1'b1;
        wen = 1'b1; wadd = 5'd5; wdata = 32'hDEADBEEF; sb_set = 1'b1; sb_add = 5'd6;
        step();
        idle();
        ren = 1'b1; set_radd(0, 5); set_radd(1, 6);
        step();
        checks++;
        if (rd(0) !== 32'hDEADBEEF || rbusy[1] !== 1'b1) begin
            failures++;
            $display("FAIL reset_prewrite: x5=%h busy6=%b required deadbeef/1", rd(0), rbusy[1]);
        end
        #2;
        RSTn = 1'b0;
        #1;
        model_reset();
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd(p) !== '0 || rbusy[p] !== 1'b0) begin
                failures++;
                $display("FAIL reset_async port%0d: rdata=%h busy=%b required 0/0", p, rd(p), rbusy[p]);
            end
        end
        @(posedge CLK); #1;
        RSTn = 1'b1;
        step();
        checks++;
        if (rd(0) !== '0 || rbusy[1] !== 1'b0) begin
            failures++;
            $display("FAIL reset_after: x5=%h busy6=%b required 0/0", rd(0), rbusy[1]);
        end
        idle();
    endtask

    task automatic test_x0();
        wen = 1'b1; wadd = '0; wdata = 32'h1234; sb_set = 1'b1; sb_add = '0;
        ren = 1'b1; radd = '0;
        step();
        idle();
        ren = 1'b1; radd = '0;
        step();
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd(p) !== '0 || rbusy[p] !== 1'b0) begin
                failures++;
                $display("FAIL x0 port%0d: rdata=%h busy=%b required 0/0", p, rd(p), rbusy[p]);
            end
        end
        idle();
    endtask

    task automatic test_same_edge();
        logic [XLEN-1:0] want;
        wen = 1'b1; wadd = 5'd7; wdata = 32'h11;
        step();
        idle();
        wen = 1'b1; wadd = 5'd7; wdata = 32'hA5A5A5A5;
        ren = 1'b1; set_radd(0, 7);
        step();
        want = BYP ? 32'hA5A5A5A5 : 32'h11;
        checks++;
        if (rd(0) !== want) begin
            failures++;
            $display("FAIL same_edge: rdata0=%h required %h", rd(0), want);
        end
        idle();
        ren = 1'b1; set_radd(0, 7);
        step();
        checks++;
        if (rd(0) !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL same_edge_next: rdata0=%h required a5a5a5a5", rd(0));
        end
        idle();
    endtask

    task automatic test_stall();
        logic [XLEN-1:0] x3_old;
        x3_old = mdl_reg[3];
        wen = 1'b1; wadd = 5'd10; wdata = 32'h42;
        step();
        idle();
        ren = 1'b1; set_radd(1, 10);
        step();
        checks++;
        if (rd(1) !== 32'h42) begin
            failures++;
            $display("FAIL stall_setup: rdata1=%h required 42", rd(1));
        end
        stall = 1'b1; ren = 1'b1; set_radd(1, 3);
        wen = 1'b1; wadd = 5'd3; wdata = 32'hCAFE0003; sb_set = 1'b1; sb_add = 5'd4;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (rd(1) !== 32'h42 || rbusy[1] !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc%0d: rdata1=%h busy=%b required 42/0", c, rd(1), rbusy[1]);
            end
        end
        idle();
        ren = 1'b1; set_radd(0, 3); set_radd(1, 4);
        step();
        checks++;
        if (rd(0) !== x3_old || rbusy[1] !== 1'b0) begin
            failures++;
            $display("FAIL stall_after: x3=%h busy4=%b required %h/0", rd(0), rbusy[1], x3_old);
        end
        idle();
    endtask

    task automatic test_scoreboard();
        sb_set = 1'b1; sb_add = 5'd9;
        step();
        idle();
        ren = 1'b1; set_radd(0, 9);
        step();
        checks++;
        if (rbusy[0] !== 1'b1) begin
            failures++;
            $display("FAIL sb_set: busy9=%b required 1", rbusy[0]);
        end
        wen = 1'b1; wadd = 5'd9; wdata = 32'h99; sb_set = 1'b1; sb_add = 5'd9;
        step();
        idle();
        ren = 1'b1; set_radd(0, 9);
        step();
        checks++;
        if (rbusy[0] !== 1'b1) begin
            failures++;
            $display("FAIL sb_set_wins: busy9=%b required 1", rbusy[0]);
        end
        idle();
        wen = 1'b1; wadd = 5'd9; wdata = 32'h9A;
        step();
        idle();
        ren = 1'b1; set_radd(0, 9);
        step();
        checks++;
        if (rbusy[0] !== 1'b0 || rd(0) !== 32'h9A) begin
            failures++;
            $display("FAIL sb_clear: busy9=%b x9=%h required 0/9a", rbusy[0], rd(0));
        end
        idle();
    endtask

    task automatic test_multiport();
        wen = 1'b1; wadd = 5'd2; wdata = 32'h77;
        step();
        idle();
        for (int p = 0; p < NRD; p++) set_radd(p, 2);
        step();
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd(p) !== '0 || rbusy[p] !== 1'b0) begin
                failures++;
                $display("FAIL mp_ren0 port%0d: rdata=%h busy=%b required 0/0", p, rd(p), rbusy[p]);
            end
        end
        ren = 1'b1;
        step();
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd(p) !== 32'h77) begin
                failures++;
                $display("FAIL mp_ren1 port%0d: rdata=%h required 77", p, rd(p));
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            stall  = ($urandom_range(0, 4) == 0);
            ren    = ($urandom_range(0, 5) != 0);
            wen    = $urandom_range(0, 1) == 1;
            wadd   = AW'($urandom_range(0, 7));
            wdata  = $urandom;
            sb_set = $urandom_range(0, 2) == 0;
            sb_add = AW'($urandom_range(0, 7));
            for (int p = 0; p < NRD; p++) set_radd(p, $urandom_range(0, 8));
            step();
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd(p) !== exp_rd[p] || rbusy[p] !== exp_rb[p]) begin
                    failures++;
                    $display("FAIL random cyc%0d port%0d: rdata=%h busy=%b required %h/%b",
                             c, p, rd(p), rbusy[p], exp_rd[p], exp_rb[p]);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_x0();
        test_same_edge();
        test_stall();
        test_scoreboard();
        test_multiport();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file with registered reads, a hardwired zero register, stall-aware read hold, and a per-register pending-write scoreboard. It sits between decode and execute in the pipeline: decode presents source addresses and issues destination reservations, writeback returns results, and execute consumes the registered operands and busy flags one cycle later.

## Interface
- XLEN, 32: register data width in bits.
- DEPTH, 32: number of architectural registers; power of two, at least 2.
- NRD, 2: number of read ports, 1 to 4.
- AW (derived, not overridable): $clog2(DEPTH).

- CLK  in  1  rising-edge clock.
- RSTn  in  1  reset; asynchronous assert, active-low, synchronous release.
- stall  in  1  pipeline freeze; blocks all state updates and holds all outputs.
- ren  in  1  read enable for all ports.
- radd  in  NRD*AW  read addresses; port p is bits [p*AW +: AW].
- rdata  out  NRD*XLEN  registered read data, packed the same way as radd.
- rbusy  out  NRD  registered scoreboard busy flag per read port.
- wen  in  1  writeback enable.
- wadd  in  AW  writeback address.
- wdata  in  XLEN  writeback data.
- sb_set  in  1  reserve a destination register (instruction issued).
- sb_add  in  AW  address to reserve.

## Operation
- Register 0 always reads 0, is never busy, and ignores writes and reservations.
- Write: on a clock edge with !stall, wen and wadd != 0, register wadd takes wdata.
- Scoreboard: one busy bit per register.
  - Set on !stall, sb_set and sb_add != 0.
  - Cleared on !stall, wen and wadd == that register.
  - If set and clear hit the same register in the same cycle, set wins (a new producer was issued).
- Read, per port p, at each clock edge:
  - stall = 1: rdata[p] and rbusy[p] hold.
  - stall = 0, ren = 0: rdata[p] <= 0 and rbusy[p] <= 0.
  - stall = 0, ren = 1: rdata[p] <= value of register radd[p], with the bypass rule in Configuration applied; rbusy[p] <= next-state busy bit of radd[p], i.e. the value after this edge's set/clear.
- Several ports may read the same address; each gets the same value.
- All arithmetic is address compare only; no data-width conversion.

## Timing
- Reset (RSTn low): all registers, all busy bits, rdata and rbusy go to 0 immediately, with no clock needed. Reset asserted mid-operation discards any in-flight write or reservation.
- Read latency: 1 cycle from radd/ren to rdata/rbusy.
- Write latency: a write is visible in the array 1 cycle after the edge. Without bypass, a read at the same edge returns the old value.
- Stall: all inputs sampled on a stalled edge are ignored, including wen, sb_set and ren. No write is lost-and-replayed; upstream must hold its requests until stall drops.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A same-edge read of wadd (wen = 1, stall = 0, wadd != 0) returns wdata.
  - When the bypass fires, rbusy for that port reflects the post-clear state, unless sb_set targets the same address.
- REGFILE_BYPASS_EN undefined: a same-edge read returns the pre-write value; the busy flag still follows the next-state rule.

## Structure
- Shared package regfile_pkg holds the default XLEN, DEPTH and NRD constants and the reg_addr_t and reg_data_t typedefs used by decode and writeback.
- One sub-module, regfile_scoreboard: the busy-bit vector with set/clear priority and an NRD-port next-state lookup. The data array and read registers stay in regfile_mp.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse RSTn low mid-cycle → rdata and rbusy are 0 immediately; reading x5 afterwards returns 0.
- x0: wen with wadd = 0, wdata = 0x1234, plus sb_set on 0 → reading x0 gives rdata 0 and rbusy 0.
- Same-edge read/write: wadd = radd[0] = 7, wdata = 0xA5A5A5A5, old value 0x11 → rdata[0] = 0xA5A5A5A5 with REGFILE_BYPASS_EN defined, 0x11 without it; the next cycle reads 0xA5A5A5A5 in both builds.
- Stall: with rdata[1] = 0x42, assert stall for 3 cycles while driving wen to x3 and sb_set on x4 → rdata holds 0x42, x3 is unchanged and x4 is not busy afterwards.
- Scoreboard: sb_set x9; next cycle, read x9 → rbusy = 1; then wen to x9 together with sb_set on x9 → x9 stays busy; then wen alone → the following read gives rbusy = 0.
- Multi-port, NRD = 4: all ports read x2 = 0x77 while ren = 0 → all outputs are 0; then ren = 1 → all four ports return 0x77.
